// File: rtl/calc_operand_sequencer.sv
// Operand/opcode capture sequencer feeding the calculator ALU over one shared input bus.
// Optional load debounce filter is enabled by defining LOAD_DEBOUNCE_EN.
module calc_operand_sequencer #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       op_in,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] io_oe,
    output logic [3:0]       status,
    output logic [2:0]       op_count
);

    typedef enum logic [3:0] {
        WAIT_A = 4'b0001,
        WAIT_B = 4'b0010,
        EXEC   = 4'b0100,
        SHOW   = 4'b1000
    } state_t;

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
            $error("calc_operand_sequencer: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
        end
    endgenerate

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_p;
    logic                   level;
    logic                   level_d;
    logic                   load_rise;

    // Synchronizer: load is asynchronous, so it only enters logic through this chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], load};
        end
    end

`ifdef LOAD_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] deb_cnt;
    logic             deb_level;

    // Filtered level flips only once DEBOUNCE_CYCLES consecutive samples disagree with it
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (sync_p[SYNC_STAGES-1] != deb_level) begin
            if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_level <= sync_p[SYNC_STAGES-1];
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign level = deb_level;
`else
    assign level = sync_p[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign load_rise = level & ~level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_A;
            data_a       <= '0;
            data_b       <= '0;
            alu_sel      <= '0;
            result       <= '0;
            op_count     <= '0;
            result_valid <= 1'b0;
            io_oe        <= '0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (load_rise) begin
                        data_a <= data_in;
                        state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_rise) begin
                        data_b  <= data_in;
                        alu_sel <= op_in;
                        state   <= EXEC;
                    end
                end
                // Single unconditional cycle; a load_rise here is intentionally ignored
                EXEC: begin
                    result       <= alu_y;
                    op_count     <= op_count + 3'd1;
                    result_valid <= 1'b1;
                    io_oe        <= '1;
                    state        <= SHOW;
                end
                SHOW: begin
                    if (load_rise) begin
                        result_valid <= 1'b0;
                        io_oe        <= '0;
                        state        <= WAIT_A;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    io_oe        <= '0;
                    state        <= WAIT_A;
                end
            endcase
        end
    end

    assign status = state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with an adder standing in for the ALU.
module tb_calc_operand_sequencer;

`ifdef LOAD_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] data_in;
    logic [3:0] op_in;
    logic [7:0] alu_y;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [3:0] alu_sel;
    logic [7:0] result;
    logic       result_valid;
    logic [7:0] io_oe;
    logic [3:0] status;
    logic [2:0] op_count;

    int tests = 0;
    int fails = 0;

    calc_operand_sequencer #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .data_in(data_in),
        .op_in(op_in),
        .alu_y(alu_y),
        .data_a(data_a),
        .data_b(data_b),
        .alu_sel(alu_sel),
        .result(result),
        .result_valid(result_valid),
        .io_oe(io_oe),
        .status(status),
        .op_count(op_count)
    );

    assign alu_y = data_a + data_b;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; holds load long enough to register, then low long enough to re-arm.
    task automatic pulse_load(input logic [7:0] d, input logic [3:0] op);
        data_in = d;
        op_in   = op;
        load    = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        load = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_status"}, status, 4'b0001);
        check_eq({tag, "_data_a"}, data_a, 8'h00);
        check_eq({tag, "_data_b"}, data_b, 8'h00);
        check_eq({tag, "_result"}, result, 8'h00);
        check_eq({tag, "_alu_sel"}, alu_sel, 4'h0);
        check_eq({tag, "_op_count"}, op_count, 3'd0);
        check_eq({tag, "_io_oe"}, io_oe, 8'h00);
        check_eq({tag, "_result_valid"}, result_valid, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        data_in = 8'h00;
        op_in   = 4'h0;
        @(negedge clk);
        do_reset();
        check_reset_values("reset");
        @(negedge clk);
        check_eq("reset_idle_status", status, 4'b0001);

        pulse_load(8'h25, 4'h0);
        check_eq("seq1_data_a", data_a, 8'h25);
        check_eq("seq1_status_b", status, 4'b0010);
        check_eq("seq1_valid_b", result_valid, 1'b0);
        pulse_load(8'h13, 4'h0);
        check_eq("seq1_data_b", data_b, 8'h13);
        check_eq("seq1_alu_sel", alu_sel, 4'h0);
        check_eq("seq1_result", result, 8'h38);
        check_eq("seq1_valid", result_valid, 1'b1);
        check_eq("seq1_io_oe", io_oe, 8'hFF);
        check_eq("seq1_op_count", op_count, 3'd1);
        check_eq("seq1_status_show", status, 4'b1000);
        pulse_load(8'h00, 4'h0);
        check_eq("seq1_status_a", status, 4'b0001);
        check_eq("seq1_io_oe_off", io_oe, 8'h00);
        check_eq("seq1_valid_off", result_valid, 1'b0);
        check_eq("seq1_result_kept", result, 8'h38);
        check_eq("seq1_data_a_kept", data_a, 8'h25);

        pulse_load(8'hF0, 4'h3);
        pulse_load(8'h20, 4'hA);
        check_eq("seq2_alu_sel", alu_sel, 4'hA);
        check_eq("seq2_result_wrap", result, 8'h10);
        check_eq("seq2_op_count", op_count, 3'd2);
        check_eq("seq2_data_a", data_a, 8'hF0);
        pulse_load(8'h00, 4'h0);
        check_eq("seq2_status_a", status, 4'b0001);

        // Held load: one capture exactly LAT edges after the first sampling edge
        data_in = 8'h5A;
        load    = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            check_eq($sformatf("held_pre_capture_%0d", i), status, 4'b0001);
        end
        @(negedge clk);
        check_eq("held_capture_status", status, 4'b0010);
        check_eq("held_capture_data_a", data_a, 8'h5A);
        data_in = 8'h11;
        repeat (19 - LAT) @(negedge clk);
        check_eq("held_still_b", status, 4'b0010);
        check_eq("held_no_recapture", data_a, 8'h5A);
        load = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check_eq("held_release_b", status, 4'b0010);

        // Reset mid-operation from WAIT_B
        do_reset();
        pulse_load(8'hFF, 4'h0);
        check_eq("mid_data_a", data_a, 8'hFF);
        check_eq("mid_status_b", status, 4'b0010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("mid_reset");

        // Load high only while in reset is discarded
        rst  = 1'b1;
        load = 1'b1;
        data_in = 8'h66;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        check_eq("straddle_status", status, 4'b0001);
        check_eq("straddle_data_a", data_a, 8'h00);
        pulse_load(8'h77, 4'h0);
        check_eq("after_release_data_a", data_a, 8'h77);
        check_eq("after_release_status", status, 4'b0010);

`ifdef LOAD_DEBOUNCE_EN
        do_reset();
        data_in = 8'h99;
        load    = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("glitch_status", status, 4'b0001);
        check_eq("glitch_data_a", data_a, 8'h00);
`endif

        // Eight full operations: op_count 1..7 then wraps to 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic [2:0] cnt;
            a   = 8'(i * 16 + 1);
            b   = 8'(8'h30 + i);
            cnt = 3'(i + 1);
            pulse_load(a, 4'h0);
            pulse_load(b, 4'(i));
            check_eq($sformatf("wrap_op_count_%0d", i), op_count, cnt);
            check_eq($sformatf("wrap_result_%0d", i), result, 8'(a + b));
            check_eq($sformatf("wrap_alu_sel_%0d", i), alu_sel, 4'(i));
            check_eq($sformatf("wrap_status_%0d", i), status, 4'b1000);
            pulse_load(8'h00, 4'h0);
        end
        check_eq("wrap_final_count", op_count, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_operand_sequencer.md
Name: calc_operand_sequencer

Overview:
- Front-end stage that feeds the calculator ALU. Operands and opcode share one 8-bit input bus, driven from switches/pins, and are captured in sequence under a single "load" button.
- Block presents stable data_a, data_b and alu_sel to the combinational ALU, registers the ALU result, and turns the bidirectional IO bank to output while the result is shown.
- Also supplies the 4-bit status and 3-bit operation counter shown on the dedicated outputs.

Parameters:
- WIDTH, 8, operand/result width; also width of io_oe.
- SYNC_STAGES, 2, flops in the load synchronizer (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive stable samples required when LOAD_DEBOUNCE_EN is defined (minimum 1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  asynchronous button/pin; each rising edge advances the sequence.
- data_in  in  WIDTH  shared operand bus; sampled raw, and the operator holds it stable.
- op_in  in  4  ALU operation select.
- alu_y  in  WIDTH  combinational ALU result.
- data_a  out  WIDTH  operand A register.
- data_b  out  WIDTH  operand B register.
- alu_sel  out  4  registered opcode to the ALU.
- result  out  WIDTH  registered ALU result.
- result_valid  out  1  high while in SHOW.
- io_oe  out  WIDTH  bidirectional enable: all-ones in SHOW, else all-zeros.
- status  out  4  one-hot state code.
- op_count  out  3  completed-operation counter.

Behaviour:
- Synchronous reset, active-high, one clock. While rst=1 at a clock edge, the following take effect on that edge:
  - state=WAIT_A, status=4'b0001
  - data_a, data_b, result = 0
  - alu_sel=0, op_count=0, result_valid=0, io_oe=0
  - synchronizer and edge-detect flops cleared (debounce counter too, if present)
- Reset mid-operation abandons the sequence with no residual capture. A load edge in flight during reset is discarded.
- Load edge detection:
  - load passes through SYNC_STAGES flops; load_rise = sync_out & ~sync_out_d.
  - If edge k is the first edge sampling load=1, the capture/transition happens at edge k+SYNC_STAGES. With defaults, that is 2 cycles after first sample.
  - A held-high load yields exactly one load_rise. A new event needs load to be seen low for at least one synchronized cycle.
- States (status code):
  - WAIT_A (0001): on load_rise, data_a<=data_in and go to WAIT_B.
  - WAIT_B (0010): on load_rise, data_b<=data_in, alu_sel<=op_in and go to EXEC.
  - EXEC (0100): exactly one cycle, unconditional. result<=alu_y, op_count<=op_count+1, then go to SHOW. Any load_rise in this cycle is dropped, not queued.
  - SHOW (1000): result_valid=1 and io_oe=all-ones (registered, asserted from the first SHOW cycle). On load_rise, go to WAIT_A; io_oe and result_valid clear on that same edge.
- Register retention: data_a, data_b, alu_sel and result hold their values in every state except at their capture edge. The previous result stays readable after leaving SHOW.
- op_count is 3-bit modulo: 7 -> 0 on the 8th operation, no saturation.
- Latency: from the load_rise that captures B to result_valid=1 is 2 clock edges (EXEC, then SHOW).
- No combinational path from any input to any output. All outputs are registered or decoded from state flops.

Optional Feature:
- LOAD_DEBOUNCE_EN:
  - Defined: a debounce filter sits after the synchronizer. Filtered level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples, and edge detection uses the filtered level. Capture latency becomes SYNC_STAGES+DEBOUNCE_CYCLES edges. Glitches shorter than DEBOUNCE_CYCLES produce no event.
  - Undefined: filter absent, with latency and behaviour exactly as above.

Test Plan:
- Reset check: assert rst 2 cycles, release -> status=0001, data_a=data_b=result=0, alu_sel=0, op_count=0, io_oe=0x00, result_valid=0.
- Full sequence: bench ALU model alu_y=data_a+data_b (mod 256). Steps:
  - data_in=0x25, pulse load -> data_a=0x25, status=0010
  - data_in=0x13, op_in=4'h0, pulse load -> data_b=0x13, alu_sel=0 -> EXEC 1 cycle -> result=0x38, result_valid=1, io_oe=0xFF, op_count=1, status=1000
  - pulse load -> status=0001, io_oe=0x00, result stays 0x38
- Held load: hold load high 20 cycles in WAIT_A with data_in=0x5A -> exactly one capture (data_a=0x5A), state WAIT_B only. Check capture edge is exactly SYNC_STAGES edges after first sample.
- op_count wrap: run 8 complete sequences -> op_count reads 1..7 then 0 on the 8th entry to SHOW.
- Reset mid-operation: capture A=0xFF, assert rst while in WAIT_B -> all reset values next edge. A load pulse straddling reset release produces no capture unless it rises after release.
- LOAD_DEBOUNCE_EN build, DEBOUNCE_CYCLES=4: 2-cycle load glitch -> no state change; 10-cycle pulse -> one capture at edge k+6.
